pulse_param_ctrl: RTL and testbench

PULSE_PARAM_CTRL -- requirements
Module: pulse_param_ctrl

---
 rtl/pulse_ctrl_pkg.sv | 30 +++
 rtl/key_repeat_timer.sv | 49 ++++
 rtl/pulse_param_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pulse_param_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse parameter controller: FSM encoding,
// key indices, lower bounds and the press priority encoder.
package pulse_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] KEY_SEL = 2'd0;
  localparam logic [1:0] KEY_UP  = 2'd1;
  localparam logic [1:0] KEY_DN  = 2'd2;
  localparam logic [1:0] KEY_CMT = 2'd3;

  // Smallest legal period; width never goes below 1.
  localparam logic [32:0] P_LOWER = 33'd2;
  localparam logic [32:0] W_LOWER = 33'd1;

  // Lowest-index press wins; returns the winning key index.
  function automatic logic [1:0] first_press(input logic [3:0] press);
    logic [1:0] idx;
    idx = KEY_CMT;
    if (press[0])      idx = KEY_SEL;
    else if (press[1]) idx = KEY_UP;
    else if (press[2]) idx = KEY_DN;
    return idx;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer for a held key: one tick after REPEAT_DLY held cycles,
// then one tick every REPEAT_PER cycles while the key stays down.
module key_repeat_timer #(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic start,
  input  logic hold,
  output logic tick
);

  localparam int MAXC = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  logic [CW-1:0] count_reg, count_next;
  logic          first_reg, first_next;

  // Tick detection and counter advance; the first interval is the long delay.
  always_comb begin
    count_next = count_reg;
    first_next = first_reg;
    tick       = hold && !start && (count_reg == (first_reg ? DLY_LAST : PER_LAST));
    if (start || !hold) begin
      count_next = '0;
      first_next = 1'b1;
    end else if (tick) begin
      count_next = '0;
      first_next = 1'b0;
    end else begin
      count_next = count_reg + CW'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= '0;
      first_reg <= 1'b1;
    end else begin
      count_reg <= count_next;
      first_reg <= first_next;
    end
  end

endmodule

// File: rtl/pulse_param_ctrl.sv
// Key-driven editor for pulse period/width with commit handshake.
// Optional feature macro: PULSE_CTRL_AUTO_REPEAT_EN enables auto-repeat
// while an up/down key is held; without it HOLD just waits for release.
module pulse_param_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int PERIOD_INIT = 1000,
  parameter int WIDTH_INIT  = 500,
  parameter int PERIOD_MAX  = 1000000,
  parameter int STEP        = 10,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_PER  = 5000000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Key_Flag,
  input  logic [3:0]  Key_State,
  output logic        Sel,
  output logic [31:0] Period,
  output logic [31:0] Width,
  output logic        Cfg_Valid,
  input  logic        Cfg_Ready
);

  localparam logic [32:0] STEP33   = 33'(STEP);
  localparam logic [31:0] STEP32   = 32'(STEP);
  localparam logic [32:0] PMAX33   = 33'(PERIOD_MAX);
  localparam logic [31:0] PMAX32   = 32'(PERIOD_MAX);
  localparam logic [31:0] P_LOW32  = 32'd2;
  localparam logic [31:0] W_LOW32  = 32'd1;
  localparam logic [31:0] P_INIT32 = 32'(PERIOD_INIT);
  localparam logic [31:0] W_INIT32 = 32'(WIDTH_INIT);

  state_t      state_reg, state_next;
  logic        sel_reg, sel_next;
  logic [31:0] p_sh_reg, w_sh_reg;
  logic [31:0] period_reg, period_next;
  logic [31:0] width_reg, width_next;
  logic        valid_reg, valid_next;
  logic [1:0]  rec_idx_reg, rec_idx_next;
  logic        step_req_reg, step_req_next;

  logic [3:0]  press;
  logic [1:0]  win_idx;
  logic        step_up;
  logic        hold_active;
  logic        tick;
  logic [32:0] p_up_sum, w_up_sum;
  logic [31:0] w_limit;
  logic [31:0] p_new, w_new;

  assign press       = Key_Flag & ~Key_State;
  assign win_idx     = first_press(press);
  assign step_up     = (rec_idx_reg == KEY_UP);
  assign hold_active = (state_reg == ST_HOLD) && !Key_State[rec_idx_reg];
  assign p_up_sum    = {1'b0, p_sh_reg} + STEP33;
  assign w_up_sum    = {1'b0, w_sh_reg} + STEP33;
  assign w_limit     = p_sh_reg - 32'd1;

`ifdef PULSE_CTRL_AUTO_REPEAT_EN
  logic timer_start;
  assign timer_start = (state_reg == ST_IDLE) && (|press) &&
                       ((win_idx == KEY_UP) || (win_idx == KEY_DN));

  key_repeat_timer #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_timer (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (timer_start),
    .hold    (hold_active),
    .tick    (tick)
  );
`else
  assign tick = 1'b0;
`endif

  // Saturating step on the selected shadow register, one cycle after the request.
  always_comb begin
    p_new = p_sh_reg;
    w_new = w_sh_reg;
    if (step_req_reg) begin
      if (!sel_reg) begin
        if (step_up)
          p_new = (p_up_sum > PMAX33) ? PMAX32 : p_up_sum[31:0];
        else
          p_new = ({1'b0, p_sh_reg} < (P_LOWER + STEP33)) ? P_LOW32 : (p_sh_reg - STEP32);
        if (w_sh_reg >= p_new)
          w_new = p_new - 32'd1;
      end else begin
        if (step_up)
          w_new = (w_up_sum > {1'b0, w_limit}) ? w_limit : w_up_sum[31:0];
        else
          w_new = ({1'b0, w_sh_reg} < (W_LOWER + STEP33)) ? W_LOW32 : (w_sh_reg - STEP32);
      end
    end
  end

  // Next-state and output logic of the edit/commit FSM.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    period_next   = period_reg;
    width_next    = width_reg;
    valid_next    = valid_reg;
    rec_idx_next  = rec_idx_reg;
    step_req_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|press) begin
          case (win_idx)
            KEY_SEL: sel_next = ~sel_reg;
            KEY_UP, KEY_DN: begin
              step_req_next = 1'b1;
              rec_idx_next  = win_idx;
              state_next    = ST_HOLD;
            end
            default: begin
              // Commit the post-step values so a pending step is not lost.
              period_next = p_new;
              width_next  = w_new;
              valid_next  = 1'b1;
              state_next  = ST_COMMIT;
            end
          endcase
        end
      end
      ST_HOLD: begin
        if (Key_State[rec_idx_reg])
          state_next = ST_IDLE;
        else if (tick)
          step_req_next = 1'b1;
      end
      ST_COMMIT: begin
        if (Cfg_Ready) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      sel_reg      <= 1'b0;
      p_sh_reg     <= P_INIT32;
      w_sh_reg     <= W_INIT32;
      period_reg   <= P_INIT32;
      width_reg    <= W_INIT32;
      valid_reg    <= 1'b0;
      rec_idx_reg  <= KEY_SEL;
      step_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      p_sh_reg     <= p_new;
      w_sh_reg     <= w_new;
      period_reg   <= period_next;
      width_reg    <= width_next;
      valid_reg    <= valid_next;
      rec_idx_reg  <= rec_idx_next;
      step_req_reg <= step_req_next;
    end
  end

  assign Sel       = sel_reg;
  assign Period    = period_reg;
  assign Width     = width_reg;
  assign Cfg_Valid = valid_reg;

endmodule

// File: tb/tb_pulse_param_ctrl.sv
// Self-checking bench for pulse_param_ctrl with a behavioural model of the
// shadow registers and committed configuration.
module tb_pulse_param_ctrl;

  localparam int P_INIT = 1000;
  localparam int W_INIT = 500;
  localparam int P_MAX  = 1100;
  localparam int STEP_V = 10;
  localparam int DLY    = 20;
  localparam int PER    = 5;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  Key_Flag = 4'h0;
  logic [3:0]  Key_State = 4'hF;
  logic        Sel;
  logic [31:0] Period;
  logic [31:0] Width;
  logic        Cfg_Valid;
  logic        Cfg_Ready = 1'b0;

  int total = 0;
  int bad = 0;

  longint m_p, m_w;
  bit     m_sel;

  pulse_param_ctrl #(
    .PERIOD_INIT (P_INIT),
    .WIDTH_INIT  (W_INIT),
    .PERIOD_MAX  (P_MAX),
    .STEP        (STEP_V),
    .REPEAT_DLY  (DLY),
    .REPEAT_PER  (PER)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Key_Flag  (Key_Flag),
    .Key_State (Key_State),
    .Sel       (Sel),
    .Period    (Period),
    .Width     (Width),
    .Cfg_Valid (Cfg_Valid),
    .Cfg_Ready (Cfg_Ready)
  );

  always #5 Clk = ~Clk;

  // Number of steps produced by holding an up/down key for n cycles
  // (n counts the press cycle itself).
  function automatic int n_steps(input int n);
`ifdef PULSE_CTRL_AUTO_REPEAT_EN
    int hc;
    hc = n - 1;
    if (hc >= DLY) return 2 + (hc - DLY) / PER;
    return 1;
`else
    return 1;
`endif
  endfunction

  function automatic void model_step(input bit up);
    if (!m_sel) begin
      if (up) m_p = (m_p + STEP_V > P_MAX) ? P_MAX : m_p + STEP_V;
      else    m_p = (m_p - STEP_V < 2) ? 2 : m_p - STEP_V;
      if (m_w >= m_p) m_w = m_p - 1;
    end else begin
      if (up) m_w = (m_w + STEP_V > m_p - 1) ? m_p - 1 : m_w + STEP_V;
      else    m_w = (m_w - STEP_V < 1) ? 1 : m_w - STEP_V;
    end
  endfunction

  function automatic void model_reset();
    m_p = P_INIT;
    m_w = W_INIT;
    m_sel = 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    Key_Flag  = 4'h0;
    Key_State = 4'hF;
    Cfg_Ready = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    model_reset();
  endtask

  // Press key idx (0..2) and hold it for n cycles, then let the FSM settle.
  task automatic press(input int idx, input int n);
    int k;
    Key_Flag[idx]  = 1'b1;
    Key_State[idx] = 1'b0;
    @(negedge Clk);
    Key_Flag = 4'h0;
    repeat (n - 1) @(negedge Clk);
    Key_State = 4'hF;
    repeat (4) @(negedge Clk);
    if (idx == 0) m_sel = ~m_sel;
    else begin
      k = n_steps(n);
      for (int i = 0; i < k; i++) model_step(idx == 1);
    end
  endtask

  // Commit, keep Cfg_Ready low for d cycles, then high; optionally press up
  // during the wait (which must be ignored).
  task automatic commit(input string name, input int d, input bit with_up);
    int vcnt;
    vcnt = 0;
    Key_Flag[3]  = 1'b1;
    Key_State[3] = 1'b0;
    @(negedge Clk);
    Key_Flag  = 4'h0;
    Key_State = 4'hF;
    for (int i = 0; i <= d; i++) begin
      if (Cfg_Valid === 1'b1) vcnt++;
      total++;
      if (Period !== m_p[31:0] || Width !== m_w[31:0]) begin
        bad++;
        $display("FAIL %s_cfg cycle %0d: got P=%0d W=%0d want P=%0d W=%0d",
                 name, i, Period, Width, m_p, m_w);
      end
      Key_Flag  = 4'h0;
      Key_State = 4'hF;
      if (with_up && i == 1) begin
        Key_Flag[1]  = 1'b1;
        Key_State[1] = 1'b0;
      end
      Cfg_Ready = (i == d);
      @(negedge Clk);
    end
    Cfg_Ready = 1'b0;
    Key_Flag  = 4'h0;
    Key_State = 4'hF;
    total++;
    if (vcnt != d + 1) begin
      bad++;
      $display("FAIL %s_valid_len: got %0d want %0d", name, vcnt, d + 1);
    end
    total++;
    if (Cfg_Valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid_drop: got %b want 0", name, Cfg_Valid);
    end
    $display("commit %s: period=%0d width=%0d ready_delay=%0d", name, Period, Width, d);
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge Clk);
    total++;
    if (Sel !== 1'b0 || Period !== 32'(P_INIT) || Width !== 32'(W_INIT) || Cfg_Valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got sel=%b P=%0d W=%0d v=%b want 0/%0d/%0d/0",
               Sel, Period, Width, Cfg_Valid, P_INIT, W_INIT);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_single_up();
    do_reset();
    press(1, 1);
    total++;
    if (Period !== 32'd1000 || Cfg_Valid !== 1'b0) begin
      bad++;
      $display("FAIL single_up_precommit: got P=%0d v=%b want 1000/0", Period, Cfg_Valid);
    end
    commit("single_up", 1, 1'b0);
    total++;
    if (Period !== 32'd1010) begin
      bad++;
      $display("FAIL single_up_period: got %0d want 1010", Period);
    end
  endtask

  task automatic test_priority();
    do_reset();
    Key_Flag  = 4'b0110;
    Key_State = 4'b1001;
    @(negedge Clk);
    Key_Flag = 4'h0;
    Key_State = 4'hF;
    repeat (4) @(negedge Clk);
    model_step(1'b1);
    commit("priority", 0, 1'b0);
    total++;
    if (Period !== 32'd1010) begin
      bad++;
      $display("FAIL priority_period: got %0d want 1010", Period);
    end
  endtask

  task automatic test_width_sat();
    do_reset();
    press(0, 1);
    total++;
    if (Sel !== 1'b1) begin
      bad++;
      $display("FAIL sel_toggle: got %b want 1", Sel);
    end
    for (int i = 0; i < 49; i++) press(1, 1);
    for (int i = 0; i < 3; i++) press(1, 1);
    commit("width_sat", 2, 1'b0);
    total++;
    if (Width !== 32'd999) begin
      bad++;
      $display("FAIL width_sat: got %0d want 999", Width);
    end
    press(0, 1);
    press(2, 1);
    commit("period_down", 1, 1'b0);
    total++;
    if (Period !== 32'd990 || Width !== 32'd989) begin
      bad++;
      $display("FAIL period_down_clamp: got P=%0d W=%0d want 990/989", Period, Width);
    end
  endtask

  task automatic test_commit_wait();
    logic [31:0] p0, w0;
    press(1, 1);
    commit("commit_wait", 5, 1'b1);
    p0 = Period;
    w0 = Width;
    commit("commit_again", 0, 1'b0);
    total++;
    if (Period !== p0 || Width !== w0) begin
      bad++;
      $display("FAIL ignored_up_in_commit: got P=%0d W=%0d want P=%0d W=%0d", Period, Width, p0, w0);
    end
  endtask

  task automatic test_hold();
    do_reset();
    press(1, 40);
    commit("hold40", 1, 1'b0);
    total++;
`ifdef PULSE_CTRL_AUTO_REPEAT_EN
    if (Period !== 32'd1050) begin
      bad++;
      $display("FAIL hold40_period: got %0d want 1050", Period);
    end
`else
    if (Period !== 32'd1010) begin
      bad++;
      $display("FAIL hold40_period: got %0d want 1010", Period);
    end
`endif
  endtask

  task automatic test_bounds();
    do_reset();
    press(2, 700);
    commit("floor", 0, 1'b0);
    press(0, 1);
    press(1, 30);
    commit("floor_width", 0, 1'b0);
    press(0, 1);
    press(1, 300);
    press(1, 300);
    commit("ceiling", 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(1, 1);
    Key_Flag[2]  = 1'b1;
    Key_State[2] = 1'b0;
    @(negedge Clk);
    Key_Flag = 4'h0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    total++;
    if (Period !== 32'(P_INIT) || Sel !== 1'b0 || Cfg_Valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_hold: got P=%0d sel=%b v=%b", Period, Sel, Cfg_Valid);
    end
    @(negedge Clk);
    Key_State = 4'hF;
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    Key_Flag[3]  = 1'b1;
    Key_State[3] = 1'b0;
    @(negedge Clk);
    Key_Flag = 4'h0;
    Key_State = 4'hF;
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++;
      if (Cfg_Valid !== 1'b0 || Period !== 32'(P_INIT)) begin
        bad++;
        $display("FAIL reset_mid_commit: cycle %0d v=%b P=%0d", i, Cfg_Valid, Period);
      end
    end
    commit("after_reset", 0, 1'b0);
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: press(0, 1);
        1: press(1, int'($urandom_range(1, 45)));
        2: press(2, int'($urandom_range(1, 45)));
        default: commit("random", int'($urandom_range(0, 4)), 1'b0);
      endcase
    end
    commit("random_final", 1, 1'b0);
    total++;
    if (Sel !== m_sel) begin
      bad++;
      $display("FAIL random_sel: got %b want %b", Sel, m_sel);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_priority();
    test_width_sat();
    test_commit_wait();
    test_hold();
    test_bounds();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
